// File: rtl/squarer_pkg.sv
// Shared types and defaults for the iterative squarer.
package squarer_pkg;

  localparam int unsigned ROOT_W_DEF = 8;
  localparam int unsigned SQ_W_DEF   = 16;

  // The odd-number term reaches 2*(2^ROOT_W-1)+1, so it needs one extra bit.
  function automatic int unsigned odd_width(input int unsigned root_w);
    return root_w + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/squarer_datapath.sv
// Odd-number accumulation datapath: (k+1)^2 = k^2 + 2k + 1.
module squarer_datapath
  import squarer_pkg::*;
#(
  parameter int unsigned ROOT_W = ROOT_W_DEF,
  parameter int unsigned SQ_W   = SQ_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              commit_i,
  input  logic [ROOT_W-1:0] valor_i,
  output logic              done_o,
  output logic [SQ_W-1:0]   square_o
);

  localparam int unsigned ODD_W = odd_width(ROOT_W);

  logic [ROOT_W-1:0] n_q,   n_d;
  logic [ROOT_W-1:0] k_q,   k_d;
  logic [ODD_W-1:0]  odd_q, odd_d;
  logic [SQ_W-1:0]   acc_q, acc_d;
  logic [SQ_W-1:0]   sq_q,  sq_d;
  logic [SQ_W-1:0]   acc_sum;

  assign acc_sum = acc_q + {{(SQ_W-ODD_W){1'b0}}, odd_q};
  assign done_o  = (k_q == n_q);

  always_comb begin
    n_d   = n_q;
    k_d   = k_q;
    odd_d = odd_q;
    acc_d = acc_q;
    sq_d  = sq_q;
    if (load_i) begin
      n_d   = valor_i;
      k_d   = '0;
      odd_d = ODD_W'(1);
      acc_d = '0;
    end else if (step_i) begin
      acc_d = acc_sum;
      odd_d = odd_q + ODD_W'(2);
      k_d   = k_q + ROOT_W'(1);
    end
    if (commit_i) begin
      sq_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q   <= '0;
      k_q   <= '0;
      odd_q <= ODD_W'(1);
      acc_q <= '0;
      sq_q  <= '0;
    end else begin
      n_q   <= n_d;
      k_q   <= k_d;
      odd_q <= odd_d;
      acc_q <= acc_d;
      sq_q  <= sq_d;
    end
  end

  assign square_o = sq_q;

endmodule

// File: rtl/squarer.sv
// Iterative 8-bit squarer: start/ready handshake, control FSM over an adder datapath.
module squarer
  import squarer_pkg::*;
#(
  parameter int unsigned ROOT_W = ROOT_W_DEF,
  parameter int unsigned SQ_W   = SQ_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ROOT_W-1:0] valor_i,
  output logic [SQ_W-1:0]   square_o,
  output logic              ready_o,
  output logic              busy_o
);

  state_e state_q, state_d;
  logic   load, step, commit, done;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (done) begin
          commit  = 1'b1;
          state_d = ST_DONE;
        end else begin
          step = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign ready_o = (state_q == ST_DONE);
  assign busy_o  = (state_q == ST_CALC);

  squarer_datapath #(
    .ROOT_W (ROOT_W),
    .SQ_W   (SQ_W)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .step_i   (step),
    .commit_i (commit),
    .valor_i  (valor_i),
    .done_o   (done),
    .square_o (square_o)
  );

endmodule

// File: tb/tb_squarer.sv
// Directed self-checking bench for the iterative squarer.
module tb_squarer;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  valor_i;
  logic [15:0] square_o;
  logic        ready_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  squarer #(
    .ROOT_W (8),
    .SQ_W   (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .valor_i  (valor_i),
    .square_o (square_o),
    .ready_o  (ready_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called in the first cycle after the accepting edge; returns cycles until ready_o.
  task automatic wait_ready(output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (ready_o !== 1'b1 && lat <= 300) begin
      if (busy_o === 1'b1) busy_cnt++;
      tick();
      if (ready_o !== 1'b1) lat++;
    end
    if (ready_o !== 1'b1) lat = -1;
  endtask

  task automatic run(input logic [7:0] v, output int lat, output int busy_cnt);
    start_i = 1'b1;
    valor_i = v;
    tick();
    start_i = 1'b0;
    valor_i = 8'hAA;
    wait_ready(lat, busy_cnt);
  endtask

  int lat, bc;
  logic [15:0] prev;
  int seen_ready;

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    valor_i = 8'h00;
    tick();
    tick();
    check("reset_square", square_o, 0);
    check("reset_ready", ready_o, 0);
    check("reset_busy", busy_o, 0);
    rst_n = 1'b1;
    valor_i = 8'h55;
    repeat (4) tick();
    check("idle_busy", busy_o, 0);
    check("idle_ready", ready_o, 0);
    check("idle_square", square_o, 0);

    run(8'd0, lat, bc);
    check("zero_latency", lat, 1);
    check("zero_busy", bc, 1);
    check("zero_square", square_o, 0);
    tick();
    check("ready_pulse_width", ready_o, 0);

    run(8'd1, lat, bc);
    check("one_latency", lat, 2);
    check("one_square", square_o, 1);
    tick();

    run(8'd255, lat, bc);
    check("max_latency", lat, 256);
    check("max_busy", bc, 256);
    check("max_square", square_o, 16'hFE01);
    tick();

    // Back-to-back: second start issued during the DONE cycle.
    run(8'd12, lat, bc);
    check("b2b_first_latency", lat, 13);
    check("b2b_first_square", square_o, 144);
    start_i = 1'b1;
    valor_i = 8'd3;
    tick();
    start_i = 1'b0;
    check("b2b_no_gap_busy", busy_o, 1);
    check("b2b_hold_square", square_o, 144);
    wait_ready(lat, bc);
    check("b2b_second_latency", lat, 4);
    check("b2b_second_square", square_o, 9);
    tick();

    // Start pulsed mid-CALC is ignored.
    start_i = 1'b1;
    valor_i = 8'd5;
    tick();
    start_i = 1'b0;
    tick();
    start_i = 1'b1;
    valor_i = 8'd7;
    tick();
    start_i = 1'b0;
    wait_ready(lat, bc);
    check("ignore_latency", lat, 4);
    check("ignore_square", square_o, 25);
    tick();
    check("ignore_no_restart", busy_o, 0);

    // Reset mid-operation.
    start_i = 1'b1;
    valor_i = 8'd200;
    tick();
    start_i = 1'b0;
    repeat (49) tick();
    check("midop_busy", busy_o, 1);
    rst_n = 1'b0;
    tick();
    check("midop_rst_square", square_o, 0);
    check("midop_rst_busy", busy_o, 0);
    rst_n = 1'b1;
    seen_ready = 0;
    for (int i = 0; i < 220; i++) begin
      if (ready_o === 1'b1) seen_ready++;
      tick();
    end
    check("midop_no_ready", seen_ready, 0);
    check("midop_square_zero", square_o, 0);

    // Sweep every root; square_o must hold its old value until each commit.
    prev = square_o;
    for (int r = 0; r < 256; r++) begin
      start_i = 1'b1;
      valor_i = r[7:0];
      tick();
      start_i = 1'b0;
      if (r == 128) check("sweep_hold", square_o, prev);
      wait_ready(lat, bc);
      check($sformatf("sweep_sq_%0d", r), square_o, r * r);
      if (r == 100) check("sweep_latency_100", lat, 101);
      prev = square_o;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
